// File: rtl/shared_value_arbiter.sv
// -----------------------------------------------------------------------------
// shared_value_arbiter
//
// Shares one WIDTH-bit value bus between NREQ requesters that all drive a
// common net. Requesters are served round-robin with a bounded hold time
// while others wait; a force override pre-empts every requester. The bus
// value is registered, and a one-cycle change strobe tells consumers when the
// registered value actually moved.
//
// Ports:
//   clk        in   clock, all state on the rising edge
//   rst        in   synchronous, active-high reset
//   req        in   [NREQ]        request per requester
//   req_data   in   [NREQ*WIDTH]  requester i value in bits [i*WIDTH +: WIDTH]
//   force_en   in   override enable
//   force_val  in   [WIDTH]       override value
//   grant      out  [NREQ]        one-hot grant, zero when idle or forced
//   owner      out  [3]           current grant holder index
//   forced     out  high while the override owns the bus
//   bus_val    out  [WIDTH]       registered bus value
//   bus_valid  out  bus_val is being driven (granted or forced)
//   changed    out  one-cycle pulse when bus_val differs from its last value
// -----------------------------------------------------------------------------
module shared_value_arbiter #(
  parameter int NREQ     = 2,
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic                  force_en,
  input  logic [WIDTH-1:0]      force_val,
  output logic [NREQ-1:0]       grant,
  output logic [2:0]            owner,
  output logic                  forced,
  output logic [WIDTH-1:0]      bus_val,
  output logic                  bus_valid,
  output logic                  changed
);

  localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GRANT  = 2'd1;
  localparam logic [1:0] S_FORCED = 2'd2;

  logic [1:0]        state;
  logic [2:0]        ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic              holder_req;
  logic              others_req;
  logic [WIDTH-1:0]  holder_data;
  logic              keep;
  logic              win_found;
  logic [2:0]        win_idx;
  logic [WIDTH-1:0]  win_data;
  logic [WIDTH-1:0]  nxt_bus;

  // Round-robin distance of requester i from the pointer, modulo NREQ.
  function automatic int rr_dist(input int i, input logic [2:0] p);
    int d;
    d = i - int'(p);
    if (d < 0) d = d + NREQ;
    return d;
  endfunction

  // Current holder's request/data and whether anyone else is waiting.
  always_comb begin
    holder_req  = 1'b0;
    holder_data = '0;
    others_req  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == 3'(i)) begin
        holder_req  = req[i];
        holder_data = req_data[i*WIDTH +: WIDTH];
      end else if (req[i]) begin
        others_req = 1'b1;
      end
    end
  end

  // The holder keeps the bus unless it releases or has used up its hold
  // budget while someone else waits.
  assign keep = (state == S_GRANT) && holder_req &&
                !((hold_cnt == HOLD_MAX) && others_req);

  // Winner search. While in GRANT the holder is excluded: either it released
  // (req already low) or it is being rotated out.
  always_comb begin
    int best_d;
    best_d    = NREQ;
    win_found = 1'b0;
    win_idx   = 3'd0;
    win_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && !((state == S_GRANT) && (owner == 3'(i))) &&
          (rr_dist(i, ptr) < best_d)) begin
        best_d    = rr_dist(i, ptr);
        win_found = 1'b1;
        win_idx   = 3'(i);
        win_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // With no winner the bus keeps its last value even though it goes invalid.
  always_comb begin
    if (force_en)       nxt_bus = force_val;
    else if (keep)      nxt_bus = holder_data;
    else if (win_found) nxt_bus = win_data;
    else                nxt_bus = bus_val;
  end

  // Registered outputs and control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= 3'd0;
      hold_cnt  <= '0;
      grant     <= '0;
      owner     <= 3'd0;
      forced    <= 1'b0;
      bus_val   <= '0;
      bus_valid <= 1'b0;
      changed   <= 1'b0;
    end else begin
      bus_val <= nxt_bus;
      changed <= (nxt_bus != bus_val);
      if (force_en) begin
        // ptr and hold_cnt stay frozen while forced
        state     <= S_FORCED;
        grant     <= '0;
        forced    <= 1'b1;
        bus_valid <= 1'b1;
      end else begin
        forced <= 1'b0;
        if (keep) begin
          if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HOLD_W'(1);
        end else if (win_found) begin
          state     <= S_GRANT;
          grant     <= NREQ'(1) << win_idx;
          owner     <= win_idx;
          hold_cnt  <= HOLD_W'(1);
          ptr       <= (win_idx == 3'(NREQ - 1)) ? 3'd0 : win_idx + 3'd1;
          bus_valid <= 1'b1;
        end else begin
          state     <= S_IDLE;
          grant     <= '0;
          bus_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/shared_value_arbiter.md
Name: shared_value_arbiter

Overview:
- Shares one WIDTH-bit value bus between NREQ requesters, which are the drivers of a common net fanned out to several consumer instances.
- Round-robin arbitration with a bounded hold time.
- Force override that pre-empts all requesters.
- Registered bus output plus a one-cycle change strobe, so consumers can update their local monitor registers only when the value actually changes.

Parameters:
- NREQ, 2, number of requesters (2..8).
- WIDTH, 4, bus value width.
- MAX_HOLD, 4, maximum consecutive grant cycles while another requester waits (>=1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  request per requester.
- req_data  in  NREQ*WIDTH  requester i value in bits [i*WIDTH +: WIDTH].
- force_en  in  1  override enable.
- force_val  in  WIDTH  override value.
- grant  out  NREQ  one-hot grant, all zero when idle or forced.
- owner  out  3  index of the current grant holder, valid when bus_valid && !forced.
- forced  out  1  high while in FORCED.
- bus_val  out  WIDTH  registered bus value.
- bus_valid  out  1  bus_val is driven (granted or forced).
- changed  out  1  one-cycle pulse when bus_val differs from its previous registered value.

Behaviour:
- Reset (rst=1 at an edge): grant=0, owner=0, forced=0, bus_val=0, bus_valid=0, changed=0, rr pointer=0, hold_cnt=0, state=IDLE.
  - Reset asserted mid-grant or mid-force aborts the operation the same edge.
- Clocking: all outputs are registered. Inputs sampled at edge n appear on outputs after edge n (latency 1).
- States: IDLE, GRANT, FORCED.
- FORCED has highest priority. force_en=1 at any edge, from any state:
  - state=FORCED, grant=0, bus_val=force_val, bus_valid=1, forced=1.
  - force_val changes while forced are tracked each cycle.
  - rr pointer and hold_cnt are frozen.
- FORCED exit: force_en=0 at an edge → arbitrate normally that same edge.
  - If any req: go to GRANT with bus_val=winner's data.
  - Else: IDLE, bus_valid=0, bus_val holds its last value.
- Arbitration (IDLE, or a GRANT rotation event):
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, … mod NREQ.
  - Effects: grant=1<<i, owner=i, hold_cnt=1, ptr=(i+1) mod NREQ, state=GRANT, bus_val=req_data[i], bus_valid=1.
- GRANT with holder h:
  - req[h]=0: release. Arbitrate among the others at the same edge, so there is no idle bubble. If none are requesting → IDLE, grant=0, bus_valid=0.
  - req[h]=1, hold_cnt=MAX_HOLD, and some other req=1: rotate, arbitrate excluding h.
  - Otherwise keep grant, bus_val=req_data[h] (tracks the holder's data each cycle), hold_cnt saturates at MAX_HOLD.
  - Sole requester: keeps the grant indefinitely.
- changed: 1 for exactly the cycle after any edge where the new bus_val != the old bus_val.
  - Not asserted when the value is unchanged, including a rewrite of the same value by a new owner or by force.
  - Not asserted on the reset edge.
- Width rules:
  - bus_val is exactly WIDTH bits, no extension.
  - owner is zero-padded to 3 bits.
  - Index wrap is modulo NREQ (NREQ need not be a power of two).
- Simultaneous events:
  - force_en with a release or rotation: force wins.
  - All req rising together from IDLE: the winner is decided by ptr.
  - req[i] on a requester that is not granted is ignored until it wins arbitration.

Test Plan:
- Reset, then req=2'b11, data0=3, data1=9 → after edge 1: grant=01, owner=0, bus_val=3, changed=1. After MAX_HOLD=4 grant cycles, next edge: grant=10, bus_val=9, changed=1.
- req=01 only, data0 held at 6 for 10 cycles → grant stays 01, bus_val=6, changed pulses once only.
- Granted to 0, then force_en=1 with force_val=5 → next edge: grant=0, forced=1, bus_val=5, bus_valid=1. Release with req=10 → grant=10 the following edge, ptr unchanged by the force.
- force_en=1, force_val=5 while bus_val is already 5 → changed stays 0. force_val 5→7 → changed=1 for one cycle.
- Holder 1 drops req while req0=1 → next edge grant=01, no cycle where bus_valid=0.
- rst asserted during GRANT (bus_val=9) → next edge all outputs 0. Then req=11 → grant=01 (ptr restored to 0).
